// File: rtl/seq_detector_param.sv
// seq_detector_param
// Runtime-programmable serial bit-pattern detector with a qualifier input,
// selectable overlap mode, a Mealy (combinational) and a registered match
// output, and a saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_load     strobe: latch cfg_pattern/cfg_len/cfg_overlap, restart detection
//   cfg_pattern  pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length, valid range 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     qualifies x
//   x            serial input bit
//   z            combinational match, same cycle as the completing bit
//   z_reg        registered match, one cycle after z
//   match_count  saturating count of matches
//   count_clr    synchronous clear of match_count
//   cfg_err      active configuration has an out-of-range length
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b1010,
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  output logic               z,
  output logic               z_reg,
  output logic [CNT_W-1:0]   match_count,
  input  logic               count_clr,
  output logic               cfg_err
);

  localparam logic [LEN_W:0] MAX_LEN_C = (LEN_W+1)'(MAX_LEN);

  // Active configuration
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               err_q;

  // Detection state
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               zreg_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               hist_ok;
  logic               fill_ok;
  logic               match;

  // The newest bit joins the history to form the candidate window; only the
  // low len bits take part in the comparison.
  always_comb begin
    window = {hist_q, x};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = ({1'b0, len_q} > (LEN_W+1)'(i));
    end
    hist_ok = (((window ^ pat_q) & mask) == '0);
    // fill >= len-1, written without subtraction so len=0 cannot underflow
    fill_ok = (({1'b0, fill_q} + 1'b1) >= {1'b0, len_q});
    // rst_n gating keeps z low during reset even for a len=1 configuration;
    // cfg_load drops the sample presented with it.
    match   = rst_n & in_valid & ~cfg_load & ~err_q & fill_ok & hist_ok;
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (in_valid) begin
      hist_d = window[MAX_LEN-2:0];
      if (match && !ovl_q) begin
        // Non-overlapping: the next match needs len fresh bits
        fill_d = '0;
      end else if (fill_q >= len_q) begin
        fill_d = len_q;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= RST_PATTERN;
      len_q  <= LEN_W'(RST_LEN);
      ovl_q  <= RST_OVERLAP;
      err_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      zreg_q <= 1'b0;
      cnt_q  <= '0;
    end else if (cfg_load) begin
      // Reload wins over sampling and count_clr
      pat_q  <= cfg_pattern;
      len_q  <= cfg_len;
      ovl_q  <= cfg_overlap;
      err_q  <= (cfg_len == '0) || ({1'b0, cfg_len} > MAX_LEN_C);
      hist_q <= '0;
      fill_q <= '0;
      zreg_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      zreg_q <= match;
      cnt_q  <= cnt_d;
    end
  end

  assign z           = match;
  assign z_reg       = zreg_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               x;
  logic               z;
  logic               z_reg;
  logic [CNT_W-1:0]   match_count;
  logic               count_clr;
  logic               cfg_err;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
    .z(z), .z_reg(z_reg), .match_count(match_count), .count_clr(count_clr),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: the accepted bit stream since the last restart, the
  // number of bits that may contribute to the next match, and the outputs.
  bit        m_bits[$];
  int        m_since;
  bit [7:0]  m_pat;
  int        m_len;
  bit        m_ovl;
  bit        m_err;
  bit        m_zreg;
  int        m_cnt;

  function automatic void model_reset();
    m_bits.delete();
    m_since = 0;
    m_pat   = 8'b0000_1010;
    m_len   = 4;
    m_ovl   = 1'b1;
    m_err   = 1'b0;
    m_zreg  = 1'b0;
    m_cnt   = 0;
  endfunction

  // Does the stream so far, followed by xb, end with the active pattern?
  function automatic bit model_match(input bit v, input bit ld, input bit xb);
    int n;
    if (!v || ld || m_err) return 1'b0;
    if (m_since + 1 < m_len) return 1'b0;
    if (xb != m_pat[0]) return 1'b0;
    n = m_bits.size();
    for (int k = 1; k < m_len; k++) begin
      if (m_bits[n-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock cycle: drive, check outputs before the edge, advance the model.
  task automatic step(input bit ld, input bit [7:0] pat, input int len, input bit ovl,
                      input bit v, input bit xb, input bit clr);
    bit exp_z;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    in_valid    = v;
    x           = xb;
    count_clr   = clr;
    #2;
    exp_z = model_match(v, ld, xb);
    check("z",           32'(z),           32'(exp_z));
    check("z_reg",       32'(z_reg),       32'(m_zreg));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("cfg_err",     32'(cfg_err),     32'(m_err));
    @(posedge clk);
    if (ld) begin
      m_pat   = pat;
      m_len   = len;
      m_ovl   = ovl;
      m_err   = (len == 0) || (len > MAX_LEN);
      m_bits.delete();
      m_since = 0;
      m_cnt   = 0;
      m_zreg  = 1'b0;
    end else begin
      m_zreg = exp_z;
      if (clr) m_cnt = 0;
      else if (exp_z && m_cnt < CNT_MAX) m_cnt++;
      if (v) begin
        m_bits.push_back(xb);
        if (m_bits.size() > 64) void'(m_bits.pop_front());
        if (exp_z && !m_ovl) m_since = 0;
        else m_since++;
      end
    end
    #1;
  endtask

  task automatic bit_in(input bit xb);
    step(1'b0, 8'h00, 0, 1'b0, 1'b1, xb, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input bit [7:0] pat, input int len, input bit ovl);
    step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stream(input bit [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  // Asynchronous reset asserted mid-cycle with a valid bit on the input.
  task automatic mid_reset();
    cfg_load = 1'b0; count_clr = 1'b0; in_valid = 1'b1; x = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_z",     32'(z),           32'd0);
    check("rst_z_reg", 32'(z_reg),       32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_err",   32'(cfg_err),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; x = 1'b0; count_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_z_reg", 32'(z_reg),       32'd0);
    check("reset_count", 32'(match_count), 32'd0);
    check("reset_err",   32'(cfg_err),     32'd0);
    rst_n = 1'b1;

    // Reset config 1010/len4/overlap: matches on bits 4, 6, 8
    stream(8'b1010_1010, 8);
    idle();
    check("t1_count", 32'(match_count), 32'd3);

    // Non-overlapping: matches on bits 4 and 8 only
    load(8'b0000_1010, 4, 1'b0);
    stream(8'b1010_1010, 8);
    check("t2_count", 32'(match_count), 32'd2);

    // Gap in in_valid holds the partial match
    load(8'b0000_1010, 4, 1'b1);
    stream(8'b0000_0101, 3);
    repeat (5) idle();
    bit_in(1'b0);
    check("t3_count", 32'(match_count), 32'd1);

    // Reload on bit 6 drops the sample and restarts detection
    load(8'b1110_0101, 8, 1'b1);
    stream(8'b0001_1100, 5);
    step(1'b1, 8'b1110_0101, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    stream(8'b0000_0001, 2);
    check("t4_nomatch", 32'(match_count), 32'd0);
    stream(8'b1110_0101, 8);
    check("t4_count", 32'(match_count), 32'd1);

    // len=1 saturation and count_clr priority
    load(8'b0000_0001, 1, 1'b0);
    for (int i = 0; i < 10; i++) bit_in(1'b1);
    check("t5_sat", 32'(match_count), 32'(CNT_MAX));
    step(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t5_clr", 32'(match_count), 32'd0);

    // Illegal length, recovery, then async reset mid-pattern
    load(8'b0000_1010, 0, 1'b1);
    check("t6_err", 32'(cfg_err), 32'd1);
    stream(8'b0000_1010, 4);
    check("t6_count0", 32'(match_count), 32'd0);
    load(8'b0000_1010, 4, 1'b1);
    check("t6_err_clr", 32'(cfg_err), 32'd0);
    stream(8'b0000_1010, 4);
    check("t6_count1", 32'(match_count), 32'd1);
    stream(8'b0000_0010, 2);
    mid_reset();
    stream(8'b0000_0010, 2);
    stream(8'b0000_1010, 4);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) begin
        int ln;
        ln = ($urandom_range(0, 4) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 15);
        step(1'b1, 8'($urandom), ln, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (r == 4) begin
        mid_reset();
      end else begin
        step(1'b0, 8'($urandom), $urandom_range(0, 15), 1'($urandom),
             $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 49) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. It is the successor to the fixed 4-state Mealy overlapping detector.
- Pattern, length, overlap mode and output timing are selectable per configuration load.
- Adds an input qualifier and a saturating match counter.
- Sits on a serial bit stream, e.g. a deserialiser or UART RX bit output, and flags frame or sync words to downstream control.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
LEN_W, 4, width of cfg_len; must hold MAX_LEN.
CNT_W, 8, width of the match counter.
RST_PATTERN, 8'b0000_1010, pattern loaded at reset (right-aligned, MAX_LEN bits).
RST_LEN, 4, pattern length loaded at reset.
RST_OVERLAP, 1, overlap mode loaded at reset.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_load  in  1  single-cycle strobe; latches cfg_* and restarts detection
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last
cfg_len  in  LEN_W  pattern length, 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
in_valid  in  1  x is sampled only when high
x  in  1  serial input bit
z  out  1  Mealy match: combinational, high in the same cycle as the completing bit
z_reg  out  1  Moore/registered match: one-cycle pulse, the cycle after z
match_count  out  CNT_W  number of matches since reset, cfg_load or count_clr; saturates
count_clr  in  1  synchronous clear of match_count
cfg_err  out  1  registered; high while the active cfg_len is 0 or greater than MAX_LEN

Behaviour:
Reset (async, rst_n=0):
- Active config = RST_PATTERN / RST_LEN / RST_OVERLAP.
- hist=0, fill=0, z_reg=0, match_count=0, cfg_err=0.
- z=0 while rst_n is low.

Internal state:
- hist: MAX_LEN-1 bit shift register of past accepted bits; hist[0] is the newest.
- fill: 0..len count of valid history bits.

Match condition (combinational):
- match = in_valid & ~cfg_err & (fill >= len-1) & ({hist, x} low len bits == pattern low len bits).
- z = match.

Accepted sample (in_valid=1, cfg_load=0):
- hist <= {hist[MAX_LEN-3:0], x}.
- If match and overlap=0: fill <= 0, so the next match needs len fresh bits.
- Otherwise: fill <= min(fill+1, len).

in_valid=0:
- hist and fill hold; z=0.
- z_reg still reflects the previous cycle's match.

z_reg:
- z_reg <= match every cycle, i.e. latency 1 from the completing bit.

match_count:
- Increments on match and saturates at 2^CNT_W-1 (no wrap).
- count_clr has priority over the increment; the value becomes 0 the next cycle.

cfg_load:
- Latches pattern, len and overlap.
- Sets fill=0, hist=0, match_count=0, z_reg=0, and cfg_err=(len==0 or len>MAX_LEN).
- The sample presented in the same cycle is dropped and z is forced 0.
- cfg_load has priority over both in_valid and count_clr.
- While cfg_err=1, no matches are produced; the counter holds.

len=1:
- Every accepted bit equal to pattern[0] matches.
- The overlap setting is irrelevant.

Reset mid-stream:
- Aborts any partial match immediately.
- Config returns to reset defaults; no z or z_reg pulse until len fresh bits are accepted.

Test Plan:
1. After reset (pattern 1010, len 4, overlap=1), stream 1,0,1,0,1,0,1,0 with in_valid=1 -> z high on bits 4, 6 and 8; z_reg high one cycle after each; match_count=3.
2. cfg_load pattern 1010, len 4, overlap=0, then the same 8-bit stream -> z on bits 4 and 8 only; match_count=2.
3. Overlap=1, stream 1,0,1 then in_valid=0 for 5 cycles then 0 -> z on the final bit only; z=0 during the gap; match_count=1.
4. cfg_load pattern 8'b1110_0101, len 8, then stream 11100101 asserting cfg_load again on bit 6 -> no match; fill, hist and count cleared; a later full 8-bit stream matches once.
5. CNT_W=3, len 1, pattern 1, stream ten 1s -> match_count saturates at 7; count_clr together with a matching bit -> count reads 0 the next cycle.
6. cfg_load with cfg_len=0 -> cfg_err=1; stream 1010 gives z=0 and count 0. Then cfg_len=4 reload -> cfg_err=0 and detection resumes. Also assert rst_n low mid-pattern -> all outputs 0 asynchronously.
